// File: rtl/dct8_pkg.sv
// Shared types and constants for the 8-point DCT-II MAC engine.
// The coefficient table is pre-scaled for FRAC = 10 and 12-bit signed coefficients.
package dct8_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int TABLE_CW   = 12;
    localparam int TABLE_FRAC = 10;

    typedef logic signed [TABLE_CW-1:0] coef_t;

    // C[k][n] = round(c(k) * cos((2n+1)k*pi/16) * 2^10)
    localparam coef_t COEF_TABLE [8][8] = '{
        '{ 12'sd362,  12'sd362,  12'sd362,  12'sd362,  12'sd362,  12'sd362,  12'sd362,  12'sd362},
        '{ 12'sd502,  12'sd426,  12'sd284,  12'sd100, -12'sd100, -12'sd284, -12'sd426, -12'sd502},
        '{ 12'sd473,  12'sd196, -12'sd196, -12'sd473, -12'sd473, -12'sd196,  12'sd196,  12'sd473},
        '{ 12'sd426, -12'sd100, -12'sd502, -12'sd284,  12'sd284,  12'sd502,  12'sd100, -12'sd426},
        '{ 12'sd362, -12'sd362, -12'sd362,  12'sd362,  12'sd362, -12'sd362, -12'sd362,  12'sd362},
        '{ 12'sd284, -12'sd502,  12'sd100,  12'sd426, -12'sd426, -12'sd100,  12'sd502, -12'sd284},
        '{ 12'sd196, -12'sd473,  12'sd473, -12'sd196, -12'sd196,  12'sd473, -12'sd473,  12'sd196},
        '{ 12'sd100, -12'sd284,  12'sd426, -12'sd502,  12'sd502, -12'sd426,  12'sd284, -12'sd100}
    };

    // Eight products summed need three guard bits above the product width.
    function automatic int acc_width(input int dw, input int cw);
        return dw + cw + 3;
    endfunction

endpackage

// File: rtl/dct8_mac_engine_if.sv
// Request/result bundle between the 2D DCT controller (master) and the MAC engine (slave).
// The sticky ovf flag exists only when DCT8_SAT_FLAG_EN is defined.
interface dct8_mac_engine_if #(
    parameter int DW = 12,
    parameter int OW = 16
);
    logic            start;
    logic [8*DW-1:0] x_in;
    logic            busy;
    logic            done;
    logic [8*OW-1:0] y_out;
`ifdef DCT8_SAT_FLAG_EN
    logic            ovf;

    modport master (output start, x_in, input  busy, done, y_out, ovf);
    modport slave  (input  start, x_in, output busy, done, y_out, ovf);
`else
    modport master (output start, x_in, input  busy, done, y_out);
    modport slave  (input  start, x_in, output busy, done, y_out);
`endif
endinterface

// File: rtl/dct8_coef_rom.sv
// Combinational (k, n) -> C[k][n] lookup into the shared coefficient table.
module dct8_coef_rom
    import dct8_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic [2:0]           k,
    input  logic [2:0]           n,
    output logic signed [CW-1:0] coef
);

    assign coef = CW'(COEF_TABLE[k][n]);

endmodule

// File: rtl/dct8_mac_engine.sv
// Sequential 8-point DCT-II: one multiply-accumulate per clock, 64 MACs per transform.
// Define DCT8_SAT_FLAG_EN to add the sticky saturation flag ovf.
module dct8_mac_engine
    import dct8_pkg::*;
#(
    parameter int DW   = 12,
    parameter int CW   = 12,
    parameter int FRAC = 10,
    parameter int OW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    dct8_mac_engine_if.slave bus
);

    localparam int AW = acc_width(DW, CW);
    localparam logic signed [AW-1:0] RND   = AW'(1) <<< (FRAC - 1);
    localparam logic signed [AW-1:0] Y_MAX = AW'((2 ** (OW - 1)) - 1);
    localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;

    state_t                  state;
    logic [2:0]              k;
    logic [2:0]              n;
    logic signed [AW-1:0]    acc;
    logic signed [DW-1:0]    x_reg [8];
    logic [8*OW-1:0]         y_reg;
    logic                    busy_q;
    logic                    done_q;
    logic                    accept;
    logic signed [CW-1:0]    coef;
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    mac_sum;
    logic signed [AW-1:0]    rounded;
    logic signed [OW-1:0]    y_sat;

    dct8_coef_rom #(.CW(CW)) u_rom (
        .k    (k),
        .n    (n),
        .coef (coef)
    );

    // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
    always_comb begin
        prod    = x_reg[n] * coef;
        mac_sum = acc + AW'(prod);
        rounded = (mac_sum + RND) >>> FRAC;
        y_sat   = rounded[OW-1:0];
        if (rounded > Y_MAX)
            y_sat = Y_MAX[OW-1:0];
        else if (rounded < Y_MIN)
            y_sat = Y_MIN[OW-1:0];
    end

    assign accept = bus.start && (state == IDLE || state == DONE);

`ifdef DCT8_SAT_FLAG_EN
    logic ovf_q;
    logic sat_hit;

    assign sat_hit = (rounded > Y_MAX) || (rounded < Y_MIN);
    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            n      <= '0;
            acc    <= '0;
            y_reg  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            // NOTE: the sample registers are reset too; it keeps the MAC path defined while idle.
            for (int i = 0; i < 8; i++) x_reg[i] <= '0;
`ifdef DCT8_SAT_FLAG_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state  <= CALC;
                busy_q <= 1'b1;
                k      <= '0;
                n      <= '0;
                acc    <= '0;
                for (int i = 0; i < 8; i++) x_reg[i] <= bus.x_in[i*DW +: DW];
`ifdef DCT8_SAT_FLAG_EN
                ovf_q  <= 1'b0;
`endif
            end else begin
                case (state)
                    CALC: begin
                        if (n == 3'd7) begin
                            y_reg[k*OW +: OW] <= y_sat;
                            acc <= '0;
                            n   <= '0;
                            k   <= k + 3'd1;
`ifdef DCT8_SAT_FLAG_EN
                            if (sat_hit) ovf_q <= 1'b1;
`endif
                            if (k == 3'd7) begin
                                state  <= DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end else begin
                            acc <= mac_sum;
                            n   <= n + 3'd1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.y_out = y_reg;

endmodule

// File: tb/tb_dct8_mac_engine.sv
// Self-checking bench for dct8_mac_engine built with OW = 12 so saturation is reachable.
// The reference model derives coefficients from the cosine formula and rounds with real arithmetic.
`timescale 1ns/1ps
module tb_dct8_mac_engine;

    localparam int DW   = 12;
    localparam int CW   = 12;
    localparam int FRAC = 10;
    localparam int OW   = 12;
    localparam real PI  = 3.14159265358979323846;

    typedef int vec8_t [8];
    typedef struct {
        string name;
        vec8_t x;
        vec8_t y_exp;
        bit    ovf_exp;
    } vector_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct8_mac_engine_if #(.DW(DW), .OW(OW)) bus ();

    dct8_mac_engine #(.DW(DW), .CW(CW), .FRAC(FRAC), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cref [8][8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void build_cos_table();
        real ck;
        real v;
        for (int k = 0; k < 8; k++) begin
            ck = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
            for (int n = 0; n < 8; n++) begin
                v = ck * $cos(real'((2 * n + 1) * k) * PI / 16.0) * real'(1 << FRAC);
                cref[k][n] = int'($floor(v + 0.5));
            end
        end
    endfunction

    // y[k] = sum x[n]*C[k][n], rounded half-up at 2^-FRAC, clipped to OW signed bits.
    function automatic void ref_dct(input vec8_t x, output vec8_t y, output bit sat);
        longint s;
        longint r;
        longint lim_hi;
        longint lim_lo;
        lim_hi = (longint'(1) << (OW - 1)) - 1;
        lim_lo = -(longint'(1) << (OW - 1));
        sat = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s = 0;
            for (int n = 0; n < 8; n++) s += longint'(x[n]) * longint'(cref[k][n]);
            r = longint'($floor(real'(s) / real'(1 << FRAC) + 0.5));
            if (r > lim_hi) begin r = lim_hi; sat = 1'b1; end
            if (r < lim_lo) begin r = lim_lo; sat = 1'b1; end
            y[k] = int'(r);
        end
    endfunction

    function automatic logic [8*DW-1:0] pack(input vec8_t x);
        logic [8*DW-1:0] p;
        int              v;
        for (int i = 0; i < 8; i++) begin
            v = x[i];
            p[i*DW +: DW] = v[DW-1:0];
        end
        return p;
    endfunction

    function automatic int get_y(input logic [8*OW-1:0] v, input int k);
        logic signed [OW-1:0] t;
        t = v[k*OW +: OW];
        return int'(t);
    endfunction

    task automatic check_y(input string name, input vec8_t exp);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s y%0d", name, k), get_y(bus.y_out, k), exp[k]);
    endtask

    task automatic launch(input vec8_t x);
        bus.start = 1'b1;
        bus.x_in  = pack(x);
    endtask

    // Steps negedges until done; optionally pulses start with gx at step glitch_at.
    task automatic await_done(input int glitch_at, input vec8_t gx,
                              output int lat, output int busy_cnt, output bit seen);
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            bus.start = 1'b0;
            if (lat == glitch_at) launch(gx);
            if (bus.busy) busy_cnt++;
            if (bus.done) seen = 1'b1;
        end
    endtask

    task automatic run_vec(input string name, input vec8_t x, input vec8_t y_exp, input bit ovf_exp);
        int lat;
        int bc;
        bit seen;
        @(negedge clk);
        launch(x);
        await_done(0, x, lat, bc, seen);
        check({name, " done seen"}, seen, 1);
        check({name, " latency"}, lat, 65);
        check({name, " busy cycles"}, bc, 64);
        check_y(name, y_exp);
`ifdef DCT8_SAT_FLAG_EN
        check({name, " ovf"}, bus.ovf, ovf_exp);
`else
        if (ovf_exp) ; // flag not built; saturation is still covered by y values
`endif
        @(negedge clk);
        check({name, " done width"}, bus.done, 0);
        repeat (3) @(negedge clk);
        check_y({name, " held"}, y_exp);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vector_t tbl [7];
        vec8_t   x;
        vec8_t   xa;
        vec8_t   xb;
        vec8_t   y_m;
        bit      sat_m;
        bit      seen;
        int      lat;
        int      bc;
        int      dn;
        int      scale;

        build_cos_table();
        bus.start = 1'b0;
        bus.x_in  = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        for (int k = 0; k < 8; k++) check($sformatf("reset y%0d", k), get_y(bus.y_out, k), 0);
`ifdef DCT8_SAT_FLAG_EN
        check("reset ovf", bus.ovf, 0);
`endif
        rst = 1'b0;

        tbl[0].name = "dc";        tbl[0].x = '{default: 100};
        tbl[0].y_exp = '{283, 0, 0, 0, 0, 0, 0, 0};  tbl[0].ovf_exp = 1'b0;
        tbl[1].name = "impulse";   tbl[1].x = '{1000, 0, 0, 0, 0, 0, 0, 0};
        ref_dct(tbl[1].x, tbl[1].y_exp, tbl[1].ovf_exp);
        tbl[1].y_exp[0] = 354;     tbl[1].y_exp[1] = 490;
        tbl[2].name = "alternate"; tbl[2].x = '{500, -500, 500, -500, 500, -500, 500, -500};
        ref_dct(tbl[2].x, tbl[2].y_exp, tbl[2].ovf_exp);
        tbl[3].name = "ramp";
        for (int i = 0; i < 8; i++) tbl[3].x[i] = -700 + 200 * i;
        ref_dct(tbl[3].x, tbl[3].y_exp, tbl[3].ovf_exp);
        tbl[4].name = "sat_pos";   tbl[4].x = '{default: 2047};
        tbl[4].y_exp = '{2047, 0, 0, 0, 0, 0, 0, 0}; tbl[4].ovf_exp = 1'b1;
        tbl[5].name = "zeros";     tbl[5].x = '{default: 0};
        tbl[5].y_exp = '{default: 0};                tbl[5].ovf_exp = 1'b0;
        tbl[6].name = "sat_neg";   tbl[6].x = '{default: -2048};
        ref_dct(tbl[6].x, tbl[6].y_exp, tbl[6].ovf_exp);

        foreach (tbl[i]) run_vec(tbl[i].name, tbl[i].x, tbl[i].y_exp, tbl[i].ovf_exp);

        for (int it = 0; it < 20; it++) begin
            scale = (it % 2 == 1) ? 2047 : 400;
            for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 2 * scale)) - scale;
            ref_dct(x, y_m, sat_m);
            run_vec($sformatf("random%0d", it), x, y_m, sat_m);
        end

        // start during CALC is ignored; only the first samples are transformed
        xa = '{300, -200, 150, 0, -50, 400, -350, 75};
        xb = '{-900, 800, -700, 600, -500, 400, -300, 200};
        @(negedge clk);
        launch(xa);
        await_done(20, xb, lat, bc, seen);
        check("ignore done seen", seen, 1);
        check("ignore latency", lat, 65);
        ref_dct(xa, y_m, sat_m);
        check_y("ignore", y_m);
        dn = 0;
        repeat (70) begin @(negedge clk); if (bus.done) dn++; end
        check("ignore extra done", dn, 0);

        // start in the done cycle is accepted back-to-back
        @(negedge clk);
        launch(xb);
        await_done(0, xb, lat, bc, seen);
        check("b2b first done", seen, 1);
        ref_dct(xb, y_m, sat_m);
        check_y("b2b first", y_m);
        launch(xa);
        await_done(0, xa, lat, bc, seen);
        check("b2b second done", seen, 1);
        check("b2b second latency", lat, 65);
        ref_dct(xa, y_m, sat_m);
        check_y("b2b second", y_m);
        @(negedge clk);
        check("b2b done width", bus.done, 0);

        // reset mid-transform clears everything at once and suppresses done
        @(negedge clk);
        launch(xb);
        repeat (30) begin @(negedge clk); bus.start = 1'b0; end
        #2 rst = 1'b1;
        #1;
        check("midrst busy", bus.busy, 0);
        check("midrst done", bus.done, 0);
        for (int k = 0; k < 8; k++) check($sformatf("midrst y%0d", k), get_y(bus.y_out, k), 0);
`ifdef DCT8_SAT_FLAG_EN
        check("midrst ovf", bus.ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        dn  = 0;
        repeat (80) begin @(negedge clk); if (bus.done) dn++; end
        check("midrst no done", dn, 0);
        ref_dct(xa, y_m, sat_m);
        run_vec("after_reset", xa, y_m, sat_m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
